// File: rtl/bfu_v2.sv
// NTT butterfly unit: CT/GS butterflies, pointwise Montgomery multiply and pass-through
// behind a 5-stage stall-all valid/ready pipeline. Define BFU_DIV2_EN to halve GS results mod p.
module bfu_v2 #(
   parameter int DW  = 30,
   parameter int LAT = 5
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   input  logic [DW-1:0] gamma,
   input  logic [1:0]    op,
   input  logic [DW-1:0] p,
   input  logic [DW-1:0] mu,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out1,
   output logic [DW-1:0] out2
);

   localparam logic [1:0] OP_CT   = 2'b00;
   localparam logic [1:0] OP_GS   = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   if (LAT != 5) begin : g_bad_lat
      $error("bfu_v2: only LAT=5 is supported");
   end

   function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
      logic [DW-1:0] d;
      d = a - b;
      if (a < b) d = d + m;
      return d;
   endfunction

   // u = (t + m*p) / R, then one conditional subtract since u < 2p
   function automatic logic [DW-1:0] mont_reduce(input logic [2*DW-1:0] t, input logic [DW-1:0] m,
                                                 input logic [DW-1:0] m_p);
      logic [2*DW:0] s;
      logic [DW:0]   u;
      s = {1'b0, t} + {1'b0, ({{DW{1'b0}}, m} * {{DW{1'b0}}, m_p})};
      u = s[2*DW:DW];
      if (u >= {1'b0, m_p}) u = u - {1'b0, m_p};
      return u[DW-1:0];
   endfunction

`ifdef BFU_DIV2_EN
   function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] x, input logic [DW-1:0] m);
      logic [DW:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return s[DW:1];
   endfunction
`endif

   logic            en;
   logic            v1, v2, v3, v4;
   logic [1:0]      s1_op, s2_op, s3_op, s4_op;
   logic [DW-1:0]   s1_a, s1_b, s1_g;
   logic [DW-1:0]   s2_c, s2_d, s3_c, s3_d, s4_c, s4_d;
   logic [2*DW-1:0] s2_t [2];
   logic [2*DW-1:0] s3_t [2];
   logic [DW-1:0]   s3_m [2];
   logic [DW-1:0]   s4_u [2];
   logic [DW-1:0]   pre_c;
   logic [DW-1:0]   pre_x [2];
   logic [DW-1:0]   r1, r2;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Lane 0 multiplies b (or a-b for GS), lane 1 multiplies a (MUL only); pre_c rides alongside
   always_comb begin
      pre_c    = s1_a;
      pre_x[0] = s1_b;
      pre_x[1] = '0;
      case (s1_op)
         OP_GS: begin
            pre_c    = add_mod(s1_a, s1_b, p);
            pre_x[0] = sub_mod(s1_a, s1_b, p);
         end
         OP_MUL:  pre_x[1] = s1_a;
         OP_PASS: pre_x[0] = '0;
         default: ;
      endcase
   end

   always_comb begin
      r1 = s4_c;
      r2 = s4_d;
      case (s4_op)
         OP_CT: begin
            r1 = add_mod(s4_c, s4_u[0], p);
            r2 = sub_mod(s4_c, s4_u[0], p);
         end
         OP_GS: begin
`ifdef BFU_DIV2_EN
            r1 = half_mod(s4_c, p);
            r2 = half_mod(s4_u[0], p);
`else
            r1 = s4_c;
            r2 = s4_u[0];
`endif
         end
         OP_MUL: begin
            r1 = s4_u[1];
            r2 = s4_u[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         v4        <= 1'b0;
         out_valid <= 1'b0;
         out1      <= '0;
         out2      <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         v4        <= v3;
         out_valid <= v4;
         if (v4) begin
            out1 <= r1;
            out2 <= r2;
         end
      end
   end

   // Gamma is zeroed in PASS so an undriven twiddle never reaches the multipliers
   always_ff @(posedge clk) begin
      if (en) begin
         s1_op <= op;
         s1_a  <= in1;
         s1_b  <= in2;
         s1_g  <= (op == OP_PASS) ? '0 : gamma;
         s2_op <= s1_op;
         s2_c  <= pre_c;
         s2_d  <= s1_b;
         s3_op <= s2_op;
         s3_c  <= s2_c;
         s3_d  <= s2_d;
         s4_op <= s3_op;
         s4_c  <= s3_c;
         s4_d  <= s3_d;
         for (int unsigned i = 0; i < 2; i++) begin
            s2_t[i] <= {{DW{1'b0}}, pre_x[i]} * {{DW{1'b0}}, s1_g};
            s3_t[i] <= s2_t[i];
            s3_m[i] <= s2_t[i][DW-1:0] * mu;
            s4_u[i] <= mont_reduce(s3_t[i], s3_m[i], p);
         end
      end
   end

endmodule

// File: tb/tb_bfu_v2.sv
// Bench for bfu_v2: a DW=14 instance for directed cases and a DW=30 instance for a random soak,
// both checked every cycle against a queue-based reference of the modular arithmetic.
module tb_bfu_v2;
   localparam int DWA = 14;
   localparam int DWB = 30;
   localparam logic [1:0] CT = 2'b00, GS = 2'b01, MUL = 2'b10, PASS = 2'b11;
   localparam longint unsigned PA = 64'd12289;
   localparam longint unsigned PB = 64'd343576577;

   typedef struct {
      logic [63:0] res;
      int          age;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        started;
   logic        done;
   logic        iv [2];
   logic        ordy [2];
   logic [1:0]  opv [2];
   logic [31:0] a1 [2];
   logic [31:0] a2 [2];
   logic [31:0] gm [2];
   logic [31:0] pv [2];
   logic [31:0] muv [2];
   logic        ira, ova, irb, ovb;
   logic [DWA-1:0] o1a, o2a;
   logic [DWB-1:0] o1b, o2b;
   logic        ir [2];
   logic        ov [2];
   logic [31:0] o1 [2];
   logic [31:0] o2 [2];

   int checks = 0;
   int failures = 0;
   int dut_ret [2];
   exp_t q [2][$];

   always_comb begin
      ir[0] = ira;  ir[1] = irb;
      ov[0] = ova;  ov[1] = ovb;
      o1[0] = 32'(o1a);  o2[0] = 32'(o2a);
      o1[1] = 32'(o1b);  o2[1] = 32'(o2b);
   end

   bfu_v2 #(.DW(DWA), .LAT(5)) dut_a (
      .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ira),
      .in1(a1[0][DWA-1:0]), .in2(a2[0][DWA-1:0]), .gamma(gm[0][DWA-1:0]), .op(opv[0]),
      .p(pv[0][DWA-1:0]), .mu(muv[0][DWA-1:0]),
      .out_valid(ova), .out_ready(ordy[0]), .out1(o1a), .out2(o2a));

   bfu_v2 #(.DW(DWB), .LAT(5)) dut_b (
      .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(irb),
      .in1(a1[1][DWB-1:0]), .in2(a2[1][DWB-1:0]), .gamma(gm[1][DWB-1:0]), .op(opv[1]),
      .p(pv[1][DWB-1:0]), .mu(muv[1][DWB-1:0]),
      .out_valid(ovb), .out_ready(ordy[1]), .out1(o1b), .out2(o2b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic longint unsigned halfm(input longint unsigned x, input longint unsigned pp);
      return x[0] ? (x + pp) >> 1 : x >> 1;
   endfunction

   // x*y*2^-dw mod p, by dividing the plain product by two dw times
   function automatic longint unsigned mm(input longint unsigned x, input longint unsigned y,
                                          input longint unsigned pp, input int dw);
      longint unsigned r;
      r = (x * y) % pp;
      for (int i = 0; i < dw; i++) r = halfm(r, pp);
      return r;
   endfunction

   function automatic longint unsigned calc_mu(input longint unsigned pp, input int dw);
      longint unsigned mask, inv;
      mask = (64'd1 << dw) - 1;
      inv  = pp;
      for (int i = 0; i < 5; i++) inv = (inv * (64'd2 - pp * inv)) & mask;
      return ((64'd1 << dw) - inv) & mask;
   endfunction

   function automatic logic [63:0] model(input int d, input logic [1:0] o, input longint unsigned a,
                                         input longint unsigned b, input longint unsigned g);
      longint unsigned pp, t, r1, r2;
      int dw;
      pp = (d == 0) ? PA : PB;
      dw = (d == 0) ? DWA : DWB;
      case (o)
         CT: begin
            t  = mm(b, g, pp, dw);
            r1 = (a + t) % pp;
            r2 = (a + pp - t) % pp;
         end
         GS: begin
            r1 = (a + b) % pp;
            r2 = mm((a + pp - b) % pp, g, pp, dw);
`ifdef BFU_DIV2_EN
            r1 = halfm(r1, pp);
            r2 = halfm(r2, pp);
`endif
         end
         MUL: begin
            r1 = mm(a, g, pp, dw);
            r2 = mm(b, g, pp, dw);
         end
         default: begin
            r1 = a;
            r2 = b;
         end
      endcase
      return {r1[31:0], r2[31:0]};
   endfunction

   // Expected-result queue: an accepted beat becomes visible after 5 enabled edges
   always @(posedge clk) begin
      bit   vis, en;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (!rstn) begin
            q[d].delete();
         end else begin
            if (ov[d] && ordy[d]) dut_ret[d]++;
            vis = (q[d].size() > 0) && (q[d][0].age >= 5);
            en  = !vis || ordy[d];
            if (en) begin
               if (vis) void'(q[d].pop_front());
               for (int i = 0; i < q[d].size(); i++) q[d][i].age++;
               if (iv[d]) begin
                  e.res = model(d, opv[d], longint'(a1[d]), longint'(a2[d]), longint'(gm[d]));
                  e.age = 1;
                  q[d].push_back(e);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      bit vis;
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            vis = (q[d].size() > 0) && (q[d][0].age >= 5);
            chk(d == 0 ? "a.out_valid" : "b.out_valid", 64'(ov[d]), 64'(vis));
            chk(d == 0 ? "a.in_ready" : "b.in_ready", 64'(ir[d]), 64'(!vis || ordy[d]));
            if (vis) begin
               chk(d == 0 ? "a.out1" : "b.out1", 64'(o1[d]), 64'(q[d][0].res[63:32]));
               chk(d == 0 ? "a.out2" : "b.out2", 64'(o2[d]), 64'(q[d][0].res[31:0]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int d, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] g);
      bit rdy;
      int n;
      n = 0;
      opv[d] = o; a1[d] = a; a2[d] = b; gm[d] = g; iv[d] = 1'b1;
      do begin
         @(negedge clk);
         rdy = ir[d];
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 100);
      if (!rdy) chk("send_wait", 64'(rdy), 64'd1);
   endtask

   task automatic one_beat(input int d, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] g,
                           input logic [31:0] e1, input logic [31:0] e2, input bit lat_chk);
      int n;
      send(d, o, a, b, g);
      iv[d] = 1'b0;
      n = 0;
      do begin
         n++;
         @(negedge clk);
      end while (!ov[d] && n < 20);
      chk("beat_wait", 64'(ov[d]), 64'd1);
      if (lat_chk) chk("latency", 64'(n), 64'd5);
      chk("beat.out1", 64'(o1[d]), 64'(e1));
      chk("beat.out2", 64'(o2[d]), 64'(e2));
      chk("beat.no_x", 64'($isunknown({o1[d], o2[d]})), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r0;
      rstn = 1'b0; started = 1'b0; done = 1'b0;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; opv[d] = CT;
         a1[d] = '0; a2[d] = '0; gm[d] = '0; dut_ret[d] = 0;
      end
      pv[0] = 32'(PA);  muv[0] = 32'(calc_mu(PA, DWA));
      pv[1] = 32'(PB);  muv[1] = 32'(calc_mu(PB, DWB));

      chk("model.mu14", calc_mu(PA, DWA), 64'd12287);
      chk("model.mm_one", mm(3, 4095, PA, DWA), 64'd3);
      chk("model.mu30", (calc_mu(PB, DWB) * PB + 1) & ((64'd1 << DWB) - 1), 64'd0);

      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      started = 1'b1;
      @(negedge clk);
      chk("reset.out_valid", 64'(ov[0]), 64'd0);
      chk("reset.out1", 64'(o1[0]), 64'd0);
      chk("reset.out2", 64'(o2[0]), 64'd0);
      chk("reset.in_ready", 64'(ir[0]), 64'd1);
      @(posedge clk);
      #1;

      one_beat(0, CT, 5, 3, 4095, 8, 2, 1'b1);
`ifdef BFU_DIV2_EN
      one_beat(0, GS, 3, 5, 4095, 4, 12288, 1'b0);
`else
      one_beat(0, GS, 3, 5, 4095, 8, 12287, 1'b0);
`endif
      one_beat(0, MUL, 2, 7, 4095, 2, 7, 1'b0);
      one_beat(0, PASS, 12288, 0, 'x, 12288, 0, 1'b0);
      gm[0] = 4095;

      // back-pressure: 8 CT beats, consumer stalls 3 cycles once results start
      r0 = dut_ret[0];
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(0, CT, 32'($urandom % 32'(PA)), 32'($urandom % 32'(PA)), 32'($urandom % 32'(PA)));
            iv[0] = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            ordy[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            ordy[0] = 1'b1;
         end
      join
      repeat (15) @(posedge clk);
      #1;
      chk("bp.count", 64'(dut_ret[0] - r0), 64'd8);

      // reset with 3 beats in flight
      for (int i = 0; i < 3; i++)
         send(0, CT, 32'($urandom % 32'(PA)), 32'($urandom % 32'(PA)), 32'($urandom % 32'(PA)));
      iv[0] = 1'b0;
      r0 = dut_ret[0];
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("mid_rst.out_valid", 64'(ov[0]), 64'd0);
      chk("mid_rst.out1", 64'(o1[0]), 64'd0);
      chk("mid_rst.out2", 64'(o2[0]), 64'd0);
      chk("mid_rst.in_ready", 64'(ir[0]), 64'd1);
      repeat (12) @(posedge clk);
      #1;
      chk("mid_rst.flushed", 64'(dut_ret[0] - r0), 64'd0);

      // random soak on the DW=30 instance
      r0 = dut_ret[1];
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               if ($urandom % 4 == 0) begin
                  iv[1] = 1'b0;
                  @(posedge clk);
                  #1;
               end
               send(1, 2'($urandom % 4), 32'($urandom % 32'(PB)), 32'($urandom % 32'(PB)),
                    32'($urandom % 32'(PB)));
            end
            iv[1] = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               ordy[1] = 1'($urandom % 2);
               @(posedge clk);
               #1;
            end
            ordy[1] = 1'b1;
         end
      join
      repeat (30) @(posedge clk);
      #1;
      chk("soak.count", 64'(dut_ret[1] - r0), 64'd200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
